// File: rtl/svm_decision_accum.sv
// Decision stage after SVM recall: sums NUM_SV sign-magnitude partial scores plus
// a bias with saturation, then holds the score and class bit on a valid/ready output.
module svm_decision_accum #(
  parameter int                       NUM_SV = 8,
  parameter int                       ACC_W  = 20,
  parameter logic signed [ACC_W-1:0]  BIAS   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_score,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] score,
  output logic             result,
  output logic             busy
);

  localparam int CNT_W = (NUM_SV > 1) ? $clog2(NUM_SV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SV - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   score_q, score_d;
  logic               result_q, result_d;

  logic [ACC_W:0]     mag_ext;
  logic [ACC_W:0]     term;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   sum_sat;
  logic               beat;
  logic               last_beat;

  // Negating a zero magnitude yields zero, so 0x8000 needs no special case.
  always_comb begin
    mag_ext = {{(ACC_W+1-15){1'b0}}, in_score[14:0]};
    term    = in_score[15] ? (~mag_ext + 1'b1) : mag_ext;
    sum     = {acc_q[ACC_W-1], acc_q} + term;
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      sum_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_sat = sum[ACC_W-1:0];
    end
  end

  assign beat      = (state_q == ACCUM) && in_valid;
  assign last_beat = beat && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      score_q  <= '0;
      result_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      score_q  <= score_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = ACCUM;
      ACCUM:   if (last_beat) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DONE);
    busy      = (state_q == ACCUM) || (state_q == DONE);
  end

  // score/result are captured together with the final sum so they are valid on DONE entry.
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    score_d  = score_q;
    result_d = result_q;
    if ((state_q == IDLE) && start) begin
      acc_d = BIAS;
      cnt_d = '0;
    end
    if (beat) begin
      acc_d = sum_sat;
      cnt_d = last_beat ? '0 : cnt_q + 1'b1;
      if (last_beat) begin
        score_d  = sum_sat;
        result_d = ~sum_sat[ACC_W-1];
      end
    end
  end

  assign score  = score_q;
  assign result = result_q;

endmodule

// File: tb/tb_svm_decision_accum.sv
// Randomised and directed bench for svm_decision_accum against an integer model
// of the bias + saturating sum of sign-magnitude scores.
module tb_svm_decision_accum;

  localparam int NSV    = 4;
  localparam int AW     = 17;
  localparam int BIAS_V = -3;
  localparam int SMAX   = (1 << (AW-1)) - 1;
  localparam int SMIN   = -(1 << (AW-1));

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_score = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] score;
  logic          result;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [15:0] bq[$];

  svm_decision_accum #(.NUM_SV(NSV), .ACC_W(AW), .BIAS(AW'(BIAS_V))) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_score(in_score), .out_valid(out_valid), .out_ready(out_ready),
    .score(score), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int sm2int(input logic [15:0] s);
    int m;
    m = int'(s[14:0]);
    return s[15] ? -m : m;
  endfunction

  function automatic int clamp(input int v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  function automatic int score_s();
    return int'($signed(score));
  endfunction

  // gap >= 0: fixed idle cycles before each beat; gap < 0: random 0..2.
  task automatic classify(input int gap, input int hold, input bit pre_ready, input bit start_in_hs);
    int acc_m;
    int cyc;
    int waitc;
    int g;
    int held;
    acc_m = BIAS_V;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    chk("in_ready_after_start", in_ready, 1);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < NSV; i++) begin
      g = (gap >= 0) ? gap : int'($urandom_range(0, 2));
      repeat (g) begin
        in_valid = 1'b0;
        in_score = 16'($urandom);
        @(negedge clk);
        cyc++;
        chk("gap_acc", int'($signed(dut.acc_q)), acc_m);
        chk("gap_cnt", int'(dut.cnt_q), i);
      end
      in_valid = 1'b1;
      in_score = bq[i];
      if (i == NSV-1) out_ready = pre_ready;
      @(negedge clk);
      cyc++;
      acc_m = clamp(acc_m + sm2int(bq[i]));
    end
    in_valid = 1'b0;
    waitc = 0;
    while (!out_valid && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("out_valid_delay", waitc, 0);
    if (gap == 0) chk("start_to_valid", cyc, NSV+1);
    chk("score", score_s(), acc_m);
    chk("result", result, (acc_m >= 0) ? 1 : 0);
    if (pre_ready) begin
      @(negedge clk);
      out_ready = 1'b0;
    end else begin
      held = score_s();
      for (int h = 0; h < hold; h++) begin
        start = (h == 1);
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_score", score_s(), held);
        chk("hold_in_ready", in_ready, 0);
      end
      start = start_in_hs;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      out_ready = 1'b0;
    end
    chk("idle_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    @(negedge clk);
    chk("idle_busy_2", busy, 0);
    chk("idle_in_ready", in_ready, 0);
    chk("score_kept", score_s(), acc_m);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_score", score_s(), 0);
    chk("rst_result", result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_start_in_ready", in_ready, 0);
    in_valid = 1'b0;

    bq = '{16'h0064, 16'h801E, 16'h0005, 16'h8050};
    classify(0, 0, 1'b0, 1'b0);
    bq = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    classify(0, 0, 1'b0, 1'b0);
    bq = '{16'h0003, 16'h0000, 16'h8000, 16'h0000};
    classify(0, 0, 1'b0, 1'b0);
    bq = '{16'h0010, 16'h8020, 16'h0030, 16'h0001};
    classify(3, 5, 1'b0, 1'b1);
    bq = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    classify(0, 0, 1'b1, 1'b0);
    bq = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    classify(0, 2, 1'b0, 1'b0);

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    in_valid = 1'b1;
    in_score = 16'h1234;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_score", score_s(), 0);
    chk("abort_acc", int'($signed(dut.acc_q)), 0);
    chk("abort_cnt", int'(dut.cnt_q), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("post_abort_in_ready", in_ready, 0);
    bq = '{16'h000A, 16'h000A, 16'h000A, 16'h000A};
    classify(0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      bq = {};
      for (int i = 0; i < NSV; i++) begin
        case ($urandom_range(0, 3))
          0:       bq.push_back(16'h8000);
          1:       bq.push_back({1'($urandom), 15'($urandom_range(0, 200))});
          default: bq.push_back(16'($urandom));
        endcase
      end
      classify(-1, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/svm_decision_accum.md
# svm_decision_accum

Sequential decision stage placed directly downstream of the SVM recall datapath. It consumes one 16-bit sign-magnitude partial score per support vector, in the same format the recall stage produces internally (bit 15 = sign, bits 14:0 = magnitude). It accumulates NUM_SV partial scores plus a bias in two's complement, then presents the final score and a one-bit class decision through a valid/ready handshake. This turns the single-pair recall into a full multi-support-vector classification.

## Interface
- NUM_SV, 8, partial scores per classification; legal range >= 1.
- ACC_W, 20, accumulator and score width, two's complement; legal range >= 17.
- BIAS, 0, signed ACC_W-bit constant loaded into the accumulator at start.

- clk  input  1  sole clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a classification; honoured only in IDLE.
- in_valid  input  1  in_score carries a valid partial score.
- in_ready  output  1  the block accepts a partial score this cycle.
- in_score  input  16  sign-magnitude partial score: [15] sign, [14:0] magnitude.
- out_valid  output  1  score and result are final.
- out_ready  input  1  the consumer takes the result.
- score  output  ACC_W  final accumulated score, two's complement.
- result  output  1  class decision: 1 when score >= 0, 0 when score < 0.
- busy  output  1  high in ACCUM and DONE.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start: acc<=BIAS, cnt<=0, go to ACCUM.
- ACCUM:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready.
  - Per accepted beat: convert in_score to two's complement. Sign 0 gives +mag; sign 1 gives -mag. Negative zero (0x8000) converts to 0.
  - Sign-extend the converted value to ACC_W+1 bits and add it to acc.
  - Saturate the sum to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1].
  - cnt increments on each accepted beat. When the beat is accepted with cnt==NUM_SV-1, go to DONE.
  - With NUM_SV=1, the first accepted beat moves the FSM to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - score and result are driven from acc and stay stable until out_valid && out_ready.
  - On the handshake, go to IDLE.
- start is ignored in ACCUM and DONE. It does not restart the run, reload acc or reset cnt.
- score and result are registered.
  - They update only when the FSM enters DONE.
  - After the handshake they keep their last values until the next DONE.
- cnt width is max(1, $clog2(NUM_SV)).

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, acc=0, cnt=0, score=0, result=0, out_valid=0, in_ready=0, busy=0.
- start sampled high in IDLE at edge k: in_ready=1 and busy=1 from cycle k+1.
- Last beat accepted at edge m: out_valid=1 from cycle m+1, and score/result are valid the same cycle.
- Minimum latency from start to out_valid is NUM_SV+1 cycles, with in_valid held high and no gaps.
- If out_ready is already high when out_valid rises, the handshake completes in that cycle.
  - The FSM is in IDLE in the next cycle.
  - start can be accepted one cycle after that.
- A start asserted in the same cycle as the DONE handshake is ignored, because the FSM is not yet in IDLE.
- rst_n asserted mid-ACCUM or mid-DONE aborts immediately to reset values. The partial sum is discarded and no out_valid is produced.
- in_valid gaps in ACCUM stall cnt and acc without limit. There is no timeout.

## Test plan
- Reset: rst_n low mid-cycle → every output 0 immediately, and in_ready stays 0 until start.
- NUM_SV=4, BIAS=0, back-to-back scores 0x0064, 0x801E, 0x0005, 0x8050 (+100, -30, +5, -80) → out_valid exactly 1 cycle after the 4th beat, score=-5 (0xFFFFB at ACC_W=20), result=0.
- NUM_SV=4, BIAS=0, four beats of 0x8000 → score=0, result=1. Repeat with BIAS=-1 → score=-1, result=0.
- Backpressure, NUM_SV=4: insert in_valid gaps of 3 cycles → cnt and acc unchanged during each gap. In DONE, hold out_ready low 5 cycles and pulse start → out_valid stays high, score stays stable, start has no effect. Raise out_ready → back to IDLE next cycle.
- Saturation, ACC_W=17, NUM_SV=4, four beats of 0x7FFF → score=65535 (max positive), result=1. Four beats of 0xFFFF → score=-65536.
- Reset mid-run: NUM_SV=4, assert rst_n after 2 accepted beats, release, then start with four beats of +10 → score=40+BIAS, with no trace of the aborted run.
